// File: rtl/timer_pkg.sv
// Shared types and constants for the seconds countdown timer peripheral.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } timer_state_e;

  localparam int unsigned ABORT_BIT = 31;
  localparam int unsigned SECONDS_W = 16;

  // Byte offsets of the TIMER registers on the CPU bus.
  localparam logic [31:0] TIMER_CTRL_OFFSET = 32'h0000_0000;
  localparam logic [31:0] TIMER_DONE_OFFSET = 32'h0000_0004;

endpackage

// File: rtl/timer_seconds_periph_if.sv
// CPU-side register strobes and status of the TIMER peripheral.
interface timer_seconds_periph_if;

  logic                             ctrl_we;
  logic [31:0]                      ctrl_wdata;
  logic                             done_we;
  logic                             done_rdata;
  logic                             busy;
  logic [timer_pkg::SECONDS_W-1:0]  remaining_s;
  logic                             tick_1s;

  modport master (
    output ctrl_we, ctrl_wdata, done_we,
    input  done_rdata, busy, remaining_s, tick_1s
  );

  modport slave (
    input  ctrl_we, ctrl_wdata, done_we,
    output done_rdata, busy, remaining_s, tick_1s
  );

endinterface

// File: rtl/timer_seconds_periph_tick_gen.sv
// Prescaler: counts enabled cycles 0..Period-1 and flags the last one.
module tick_gen #(
  parameter int unsigned Period = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Period - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = enable && !clear && (cnt_q == LastCnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/timer_seconds_periph.sv
// Memory-mapped seconds countdown timer with sticky done flag.
module timer_seconds_periph
  import timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ     = 10_000_000,
  parameter bit          Simulacion      = 1'b0,
  parameter int unsigned SIM_TICK_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_seconds_periph_if.slave bus
);

  localparam int unsigned Period = Simulacion ? SIM_TICK_CYCLES : CLK_FREQ_HZ;

  timer_state_e         state_q;
  logic [SECONDS_W-1:0] rem_q;
  logic                 done_q;
  logic                 tick_q;
  logic                 tick;

  logic                 wr_abort;
  logic [SECONDS_W-1:0] wr_secs;
  logic                 unused_wdata;

  assign wr_abort     = bus.ctrl_wdata[ABORT_BIT];
  assign wr_secs      = bus.ctrl_wdata[SECONDS_W-1:0];
  assign unused_wdata = ^bus.ctrl_wdata[ABORT_BIT-1:SECONDS_W];

  // Any control write restarts the second, so a reload discards the partial period.
  tick_gen #(
    .Period (Period)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (bus.ctrl_we),
    .enable (state_q == StRun),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      done_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (bus.ctrl_we) begin
        // A control write beats both a coincident final tick and done_we.
        if (wr_abort) begin
          state_q <= StIdle;
          rem_q   <= '0;
          done_q  <= 1'b0;
        end else if (wr_secs == '0) begin
          state_q <= StDone;
          rem_q   <= '0;
          done_q  <= 1'b1;
        end else begin
          state_q <= StRun;
          rem_q   <= wr_secs;
          done_q  <= 1'b0;
        end
      end else begin
        if (bus.done_we) begin
          done_q <= 1'b0;
        end
        unique case (state_q)
          StRun: begin
            if (tick) begin
              tick_q <= 1'b1;
              if (rem_q != '0) begin
                rem_q <= rem_q - 1'b1;
              end
              if (rem_q <= SECONDS_W'(1)) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end
          end
          StDone: begin
            if (bus.done_we) begin
              state_q <= StIdle;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.done_rdata  = done_q;
  assign bus.busy        = (state_q == StRun);
  assign bus.remaining_s = rem_q;
  assign bus.tick_1s     = tick_q;

endmodule
